// File: rtl/move_collector_if.sv
// Handshake bundle between one column's square units, the move collector and the search controller.
// The master side drives squares/controller inputs; the slave side is the collector itself.
interface move_collector_if #(
    parameter int AW = 4
);
    logic          start;
    logic [7:0]    sq_valid;
    logic [143:0]  sq_move;
    logic [7:0]    sq_hold;
    logic          col_done;
    logic          mv_valid;
    logic [17:0]   mv_data;
    logic          mv_ready;
    logic [AW:0]   count;
    logic          done;

    modport master (
        output start, sq_valid, sq_move, col_done, mv_ready,
        input  sq_hold, mv_valid, mv_data, count, done
    );

    modport slave (
        input  start, sq_valid, sq_move, col_done, mv_ready,
        output sq_hold, mv_valid, mv_data, count, done
    );
endinterface

// File: rtl/move_collector.sv
// Collects move records from the eight squares of a column and buffers them for the controller.
// Define MOVE_COLLECTOR_MVVLVA_EN to hand out the best MVV-LVA scored move first instead of FIFO order.
module move_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            reset,
    move_collector_if.slave bus
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]  winOneHot;
    logic [17:0] pushData;
    logic        full, pushEn, popEn;
    logic [AW:0] count_q, count_d;
    logic        mvValid_q, mvValid_d;
    logic [17:0] mvData_q, mvData_d;

    // Fixed priority: scanning downwards leaves the lowest valid square as the winner.
    always_comb begin
        winOneHot = '0;
        pushData  = '0;
        for (int i = 7; i >= 0; i--) begin
            if (bus.sq_valid[i]) begin
                winOneHot = 8'b1 << i;
                pushData  = bus.sq_move[18*i +: 18];
            end
        end
    end

    assign full   = (count_q == FULL);
    assign pushEn = (|bus.sq_valid) && !full && !bus.start;
    assign popEn  = mvValid_q && bus.mv_ready && !bus.start;

    always_comb begin
        if (bus.start)
            bus.sq_hold = '0;
        else if (full)
            bus.sq_hold = bus.sq_valid;
        else
            bus.sq_hold = bus.sq_valid & ~winOneHot;
    end

    assign count_d  = bus.start ? '0 : count_q + (AW+1)'(pushEn) - (AW+1)'(popEn);
    assign bus.count    = count_q;
    assign bus.mv_valid = mvValid_q;
    assign bus.mv_data  = mvData_q;
    assign bus.done     = bus.col_done && (count_q == '0) && (bus.sq_valid == '0);

`ifdef MOVE_COLLECTOR_MVVLVA_EN
    logic [17:0]      slotData [DEPTH];
    logic [DEPTH-1:0] slotValid_q, slotValid_d;
    logic [AW-1:0]    sel_q, sel_d, freeIdx, bestIdx;
    logic [5:0]       bestScore;
    logic             bestFound;

    function automatic logic [5:0] scoreOf(input logic [17:0] m);
        logic [2:0] att, vic;
        att = (m[5:3] == 3'd7) ? 3'd0 : m[5:3];
        vic = (m[2:0] == 3'd7) ? 3'd0 : m[2:0];
        return {vic, 3'd7 - att};
    endfunction

    // The slot being popped is excluded so the registered selection never re-presents it.
    always_comb begin
        freeIdx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!slotValid_q[i]) freeIdx = AW'(i);
        end
        slotValid_d = slotValid_q;
        if (popEn)  slotValid_d[sel_q]   = 1'b0;
        if (pushEn) slotValid_d[freeIdx] = 1'b1;
        if (bus.start) slotValid_d = '0;

        bestFound = 1'b0;
        bestIdx   = '0;
        bestScore = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid_q[i] && !(popEn && sel_q == AW'(i)) &&
                (!bestFound || scoreOf(slotData[i]) > bestScore)) begin
                bestFound = 1'b1;
                bestIdx   = AW'(i);
                bestScore = scoreOf(slotData[i]);
            end
        end
        sel_d     = bestFound ? bestIdx : sel_q;
        mvValid_d = bestFound && !bus.start;
        mvData_d  = (bestFound && !bus.start) ? slotData[bestIdx] : mvData_q;
    end

    always_ff @(posedge clk) begin
        if (pushEn) slotData[freeIdx] <= pushData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotValid_q <= '0;
            sel_q       <= '0;
        end else begin
            slotValid_q <= slotValid_d;
            sel_q       <= sel_d;
        end
    end
`else
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;

    // Head register is refilled from the next read slot, or from the incoming move when it lands there.
    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        mvValid_d = mvValid_q;
        mvData_d  = mvData_q;
        if (bus.start) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            mvValid_d = 1'b0;
        end else begin
            if (pushEn) wrPtr_d = wrPtr_q + AW'(1);
            if (popEn)  rdPtr_d = rdPtr_q + AW'(1);
            mvValid_d = (count_d != '0);
            if (count_d != '0)
                mvData_d = (pushEn && wrPtr_q == rdPtr_d) ? pushData : mem[rdPtr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr_q] <= pushData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            mvValid_q <= 1'b0;
            mvData_q  <= '0;
        end else begin
            count_q   <= count_d;
            mvValid_q <= mvValid_d;
            mvData_q  <= mvData_d;
        end
    end
endmodule

// File: tb/tb_move_collector.sv
// Self-checking bench for move_collector: table-driven arbitration vectors plus hand-written
// full/wrap/start/done/reset sequences, with a scoreboard queue of expected moves in pop order.
module tb_move_collector;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    move_collector_if #(.AW(AW)) bus();
    move_collector #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          compared   = 0;
    int          mismatched = 0;
    int          modelCount = 0;
    bit          autoScore  = 1'b1;
    logic [17:0] recs [8];
    logic [17:0] sbQ [$];

    typedef struct {
        logic [7:0]  valid;
        logic        ready;
        logic [7:0]  expHold;
        int          expCount;
        logic        expValid;
        logic [17:0] expData;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] lowestOneHot(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    // One clock cycle: drive, check combinational outputs, predict, clock, check registered outputs.
    task automatic applyStimulus(input logic [7:0] v, input logic rdy, input logic st,
                                 input logic cd, output logic [7:0] holdSeen);
        logic [7:0]  expHold;
        logic        popNow, accNow;
        logic [17:0] expData;
        int          win;
        bus.sq_valid = v;
        bus.mv_ready = rdy;
        bus.start    = st;
        bus.col_done = cd;
        for (int i = 0; i < 8; i++) bus.sq_move[18*i +: 18] = recs[i];
        #1;
        holdSeen = bus.sq_hold;
        if (st)                       expHold = 8'h00;
        else if (modelCount == DEPTH) expHold = v;
        else                          expHold = v & ~lowestOneHot(v);
        checkOutput("sq_hold", bus.sq_hold, expHold);
        checkOutput("done pre-edge", bus.done, cd && modelCount == 0 && v == 8'h00);
        popNow = !st && rdy && modelCount != 0;
        accNow = !st && v != 8'h00 && modelCount < DEPTH;
        if (popNow) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard: pop with no expected move, mv_data 0x%0h", bus.mv_data);
            end else begin
                expData = sbQ.pop_front();
                checkOutput("mv_data at pop", bus.mv_data, expData);
            end
        end
        if (accNow && autoScore) begin
            win = 0;
            for (int i = 7; i >= 0; i--) if (v[i]) win = i;
            sbQ.push_back(recs[win]);
        end
        if (st) begin
            modelCount = 0;
            if (autoScore) sbQ.delete();
        end else begin
            modelCount = modelCount + int'(accNow) - int'(popNow);
        end
        @(posedge clk);
        #1;
        checkOutput("count", bus.count, modelCount);
        if (autoScore) checkOutput("mv_valid", bus.mv_valid, modelCount != 0);
        checkOutput("done post-edge", bus.done, cd && modelCount == 0 && v == 8'h00);
    endtask

    initial begin
        vec_t        vecs [7];
        logic [7:0]  h;
        vecs[0] = '{8'h04, 1'b0, 8'h00, 1, 1'b1, 18'h0A5C3};
        vecs[1] = '{8'h81, 1'b0, 8'h80, 2, 1'b1, 18'h0A5C3};
        vecs[2] = '{8'h80, 1'b0, 8'h00, 3, 1'b1, 18'h0A5C3};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 2, 1'b1, 18'h12345};
        vecs[4] = '{8'h00, 1'b1, 8'h00, 1, 1'b1, 18'h2ABCD};
        vecs[5] = '{8'h00, 1'b1, 8'h00, 0, 1'b0, 18'h2ABCD};
        vecs[6] = '{8'h00, 1'b1, 8'h00, 0, 1'b0, 18'h2ABCD};

        for (int i = 0; i < 8; i++) recs[i] = 18'(32'h01000 + i);
        recs[0] = 18'h12345;
        recs[2] = 18'h0A5C3;
        recs[7] = 18'h2ABCD;

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.sq_valid = 8'h00;
        bus.sq_move  = '0;
        bus.col_done = 1'b0;
        bus.mv_ready = 1'b0;
        #12;
        checkOutput("reset count", bus.count, 0);
        checkOutput("reset mv_valid", bus.mv_valid, 0);
        checkOutput("reset mv_data", bus.mv_data, 0);
        checkOutput("reset sq_hold", bus.sq_hold, 0);
        checkOutput("reset done", bus.done, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

`ifdef MOVE_COLLECTOR_MVVLVA_EN
        $display("[TB] MVV-LVA ordering build");
        autoScore = 1'b0;
        sbQ.push_back({12'h333, 3'd1, 3'd5});
        sbQ.push_back({12'h222, 3'd5, 3'd5});
        sbQ.push_back({12'h111, 3'd1, 3'd0});
        recs[0] = {12'h111, 3'd1, 3'd0};
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        recs[0] = {12'h222, 3'd5, 3'd5};
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        recs[0] = {12'h333, 3'd1, 3'd5};
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, h);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, h);
        checkOutput("mvvlva best presented", bus.mv_data, {12'h333, 3'd1, 3'd5});
        for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, h);
        checkOutput("mvvlva drained", bus.mv_valid, 0);
        autoScore = 1'b1;
`else
        $display("[TB] arrival-order FIFO build");
        for (int k = 0; k < 7; k++) begin
            applyStimulus(vecs[k].valid, vecs[k].ready, 1'b0, 1'b0, h);
            checkOutput($sformatf("vec%0d hold", k), h, vecs[k].expHold);
            checkOutput($sformatf("vec%0d count", k), bus.count, vecs[k].expCount);
            checkOutput($sformatf("vec%0d mv_valid", k), bus.mv_valid, vecs[k].expValid);
            checkOutput($sformatf("vec%0d mv_data", k), bus.mv_data, vecs[k].expData);
        end

        for (int n = 0; n < DEPTH; n++) begin
            recs[0] = 18'(32'h10000 + n);
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        end
        checkOutput("full count", bus.count, DEPTH);
        recs[0] = 18'h10010;
        applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, h);
        checkOutput("full hold", h, 8'h01);
        checkOutput("full pop count", bus.count, DEPTH - 1);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        checkOutput("refill hold", h, 8'h00);
        checkOutput("refill count", bus.count, DEPTH);
        for (int n = 0; n < DEPTH; n++) applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, h);

        for (int n = 0; n < 20; n++) begin
            recs[0] = 18'(32'h20000 + n * 7);
            applyStimulus(8'h01, 1'b1, 1'b0, 1'b0, h);
        end
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, h);
        checkOutput("wrap drained", bus.count, 0);

        for (int n = 0; n < 5; n++) begin
            recs[0] = 18'(32'h30000 + n);
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        end
        checkOutput("pre-start count", bus.count, 5);
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b0, h);
        checkOutput("start hold", h, 8'h00);
        checkOutput("start count", bus.count, 0);
        checkOutput("start mv_valid", bus.mv_valid, 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, h);

        for (int n = 0; n < 2; n++) begin
            recs[0] = 18'(32'h35000 + n);
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b1, h);
        end
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b1, h);
        checkOutput("done with two stored", bus.done, 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, h);
        checkOutput("done with one stored", bus.done, 0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b1, h);
        checkOutput("done drained", bus.done, 1);

        for (int n = 0; n < 3; n++) begin
            recs[0] = 18'(32'h3A000 + n);
            applyStimulus(8'h01, 1'b0, 1'b0, 1'b0, h);
        end
`endif

        bus.sq_valid = 8'h01;
        bus.mv_ready = 1'b0;
        bus.col_done = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid reset count", bus.count, 0);
        checkOutput("mid reset mv_valid", bus.mv_valid, 0);
        checkOutput("mid reset mv_data", bus.mv_data, 0);
        checkOutput("mid reset sq_hold", bus.sq_hold, 8'h00);
        bus.sq_valid = 8'h00;
        #1;
        reset = 1'b0;
        modelCount = 0;
        sbQ.delete();
        @(posedge clk);
        #1;
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0, h);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
